audio_level_meter: RTL and testbench



---
 rtl/audio_level_meter.sv | 153 +++++++++++++++
 tb/tb_audio_level_meter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_level_meter.sv
// Stereo PCM signal-strength meter: channel select, saturating gain, log-scale
// level, peak hold with timed decay and a held clip indicator, driving an LED bar.
module audio_level_meter #(
  parameter int unsigned SAMPLE_W     = 32,
  parameter int unsigned NUM_LEDS     = 10,
  parameter int unsigned FLOOR_BIT    = 21,
  parameter int unsigned HOLD_CYCLES  = 25_000_000,
  parameter int unsigned DECAY_CYCLES = 2_500_000
) (
  input  logic                                 CLOCK_50,
  input  logic                                 reset,
  input  logic                                 sample_valid,
  input  logic signed [SAMPLE_W-1:0]           left_sample,
  input  logic signed [SAMPLE_W-1:0]           right_sample,
  input  logic        [1:0]                    ch_mode,
  input  logic        [1:0]                    gain,
  output logic        [NUM_LEDS-1:0]           leds,
  output logic        [$clog2(NUM_LEDS+1)-1:0] level,
  output logic        [$clog2(NUM_LEDS+1)-1:0] peak,
  output logic                                 clip
);

  localparam int unsigned LVL_W  = $clog2(NUM_LEDS + 1);
  localparam int unsigned ABS_W  = SAMPLE_W - 1;
  localparam int unsigned EXT_W  = SAMPLE_W + 3;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int unsigned DEC_W  = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] S_MAX = ~S_MIN;

  typedef enum logic {ST_HOLD, ST_DECAY} peak_state_t;

  logic signed [SAMPLE_W:0]   w_sum;
  logic        [SAMPLE_W-1:0] w_mag_l, w_mag_r, w_sel, w_gained;
  logic        [EXT_W-1:0]    w_shift;
  logic                       w_sat, w_clip_pend;
  logic        [ABS_W-1:0]    w_abs;
  logic        [LVL_W-1:0]    w_level_n, w_level_nxt, w_peak_nxt;
  logic        [HOLD_W-1:0]   w_hold_nxt;
  logic        [DEC_W-1:0]    w_decay_nxt;
  logic        [NUM_LEDS-1:0] w_leds_nxt;
  peak_state_t                w_state;

  logic                       r_valid_d1, r_clip_pend, r_clip;
  logic        [ABS_W-1:0]    r_abs;
  logic        [LVL_W-1:0]    r_level, r_peak;
  logic        [NUM_LEDS-1:0] r_leds;
  logic        [HOLD_W-1:0]   r_hold_cnt, r_clip_cnt;
  logic        [DEC_W-1:0]    r_decay_cnt;

  // Stage 1: channel select, gain with saturation, magnitude
  always_comb begin
    w_sum   = (SAMPLE_W+1)'(left_sample) + (SAMPLE_W+1)'(right_sample);
    w_mag_l = left_sample[SAMPLE_W-1]  ? SAMPLE_W'(-left_sample)  : SAMPLE_W'(left_sample);
    w_mag_r = right_sample[SAMPLE_W-1] ? SAMPLE_W'(-right_sample) : SAMPLE_W'(right_sample);
    case (ch_mode)
      2'b00:   w_sel = left_sample;
      2'b01:   w_sel = right_sample;
      2'b10:   w_sel = (w_mag_l >= w_mag_r) ? left_sample : right_sample;
      default: w_sel = SAMPLE_W'(w_sum >>> 1);
    endcase
    w_shift = {{3{w_sel[SAMPLE_W-1]}}, w_sel} << gain;
    w_sat   = ~((&w_shift[EXT_W-1:SAMPLE_W-1]) | (~|w_shift[EXT_W-1:SAMPLE_W-1]));
    if (w_sat) w_gained = w_shift[EXT_W-1] ? S_MIN : S_MAX;
    else       w_gained = w_shift[SAMPLE_W-1:0];
    // Most negative value has no positive twin; report it as full scale
    if (w_gained == S_MIN)           w_abs = '1;
    else if (w_gained[SAMPLE_W-1])   w_abs = ABS_W'(-w_gained);
    else                             w_abs = w_gained[ABS_W-1:0];
    w_clip_pend = w_sat | (w_gained == S_MIN);
  end

  // Stage 2: MSB position above the floor maps to a bar level
  always_comb begin
    w_level_n = '0;
    for (int unsigned i = 0; i < ABS_W; i++) begin
      if (r_abs[i]) begin
        if (i < FLOOR_BIT)                      w_level_n = '0;
        else if (i - FLOOR_BIT + 1 >= NUM_LEDS) w_level_n = LVL_W'(NUM_LEDS);
        else                                    w_level_n = LVL_W'(i - FLOOR_BIT + 1);
      end
    end
  end

  // Peak hold/decay next state and bar pattern
  always_comb begin
    w_level_nxt = r_valid_d1 ? w_level_n : r_level;
    w_peak_nxt  = r_peak;
    w_hold_nxt  = r_hold_cnt;
    w_decay_nxt = r_decay_cnt;
    w_state     = (r_hold_cnt != '0) ? ST_HOLD : ST_DECAY;
    if (r_valid_d1 && (w_level_n >= r_peak)) begin
      w_peak_nxt  = w_level_n;
      w_hold_nxt  = HOLD_W'(HOLD_CYCLES);
      w_decay_nxt = '0;
    end else begin
      case (w_state)
        ST_HOLD: w_hold_nxt = r_hold_cnt - HOLD_W'(1);
        default: begin
          if (r_decay_cnt == DEC_W'(DECAY_CYCLES - 1)) begin
            w_decay_nxt = '0;
            if (r_peak > w_level_nxt) w_peak_nxt = r_peak - LVL_W'(1);
          end else begin
            w_decay_nxt = r_decay_cnt + DEC_W'(1);
          end
        end
      endcase
    end
    w_leds_nxt = '0;
    for (int unsigned k = 0; k < NUM_LEDS; k++) begin
      w_leds_nxt[k] = (w_level_nxt > LVL_W'(k)) | (w_peak_nxt == LVL_W'(k + 1));
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_valid_d1  <= 1'b0;
      r_clip_pend <= 1'b0;
      r_abs       <= '0;
      r_level     <= '0;
      r_peak      <= '0;
      r_leds      <= '0;
      r_hold_cnt  <= '0;
      r_decay_cnt <= '0;
      r_clip_cnt  <= '0;
      r_clip      <= 1'b0;
    end else begin
      r_valid_d1 <= sample_valid;
      if (sample_valid) begin
        r_abs       <= w_abs;
        r_clip_pend <= w_clip_pend;
      end
      r_level     <= w_level_nxt;
      r_peak      <= w_peak_nxt;
      r_leds      <= w_leds_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_decay_cnt <= w_decay_nxt;
      if (r_valid_d1 && r_clip_pend) begin
        r_clip     <= (HOLD_CYCLES != 0);
        r_clip_cnt <= HOLD_W'(HOLD_CYCLES);
      end else if (r_clip_cnt != '0) begin
        r_clip_cnt <= r_clip_cnt - HOLD_W'(1);
        if (r_clip_cnt == HOLD_W'(1)) r_clip <= 1'b0;
      end
    end
  end

  assign leds  = r_leds;
  assign level = r_level;
  assign peak  = r_peak;
  assign clip  = r_clip;

endmodule

// File: tb/tb_audio_level_meter.sv
// Self-checking bench for audio_level_meter: reference model feeds a queue of
// expected levels/clip flags that are compared as the pipeline produces them.
module tb_audio_level_meter;

  localparam int unsigned SW = 32;
  localparam int unsigned NL = 10;
  localparam int unsigned FB = 21;
  localparam int unsigned HC = 8;
  localparam int unsigned DC = 4;
  localparam int unsigned LW = $clog2(NL + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_valid;
  logic [SW-1:0] left_sample, right_sample;
  logic [1:0]    ch_mode, gain;
  logic [NL-1:0] leds;
  logic [LW-1:0] level, peak;
  logic          clip;

  int checks   = 0;
  int failures = 0;
  int unsigned q_lvl[$];
  bit          q_clip[$];

  audio_level_meter #(
    .SAMPLE_W(SW), .NUM_LEDS(NL), .FLOOR_BIT(FB),
    .HOLD_CYCLES(HC), .DECAY_CYCLES(DC)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .sample_valid(sample_valid),
    .left_sample(left_sample), .right_sample(right_sample),
    .ch_mode(ch_mode), .gain(gain),
    .leds(leds), .level(level), .peak(peak), .clip(clip)
  );

  always #5 clk = ~clk;

  function automatic longint mag(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: wide-integer arithmetic, level by threshold counting
  function automatic void model(input logic [31:0] l, input logic [31:0] r,
                                input logic [1:0] m, input logic [1:0] g,
                                output int unsigned lvl, output bit clp);
    longint ls, rs, v, hi, lo, a;
    ls = longint'($signed(l));
    rs = longint'($signed(r));
    case (m)
      2'd0:    v = ls;
      2'd1:    v = rs;
      2'd2:    v = (mag(ls) >= mag(rs)) ? ls : rs;
      default: v = (ls + rs) >>> 1;
    endcase
    v   = v * (longint'(1) << g);
    hi  = (longint'(1) << 31) - 1;
    lo  = -(longint'(1) << 31);
    clp = 1'b0;
    if (v > hi) begin v = hi; clp = 1'b1; end
    if (v < lo) begin v = lo; clp = 1'b1; end
    if (v == lo) begin a = hi; clp = 1'b1; end
    else a = mag(v);
    lvl = 0;
    for (int k = 1; k <= int'(NL); k++)
      if (a >= (longint'(1) << (int'(FB) + k - 1))) lvl = k;
  endfunction

  function automatic logic [NL-1:0] exp_leds(input int unsigned lv, input int unsigned pk);
    logic [NL-1:0] t;
    t = NL'((32'd1 << lv) - 32'd1);
    if (pk > 0) t = t | NL'(32'd1 << (pk - 1));
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    step();
    reset = 1'b0;
    q_lvl.delete();
    q_clip.delete();
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r,
                      input logic [1:0] m, input logic [1:0] g, input bit track);
    int unsigned lv;
    bit cp;
    left_sample = l; right_sample = r; ch_mode = m; gain = g;
    sample_valid = 1'b1;
    if (track) begin
      model(l, r, m, g, lv, cp);
      q_lvl.push_back(lv);
      q_clip.push_back(cp);
    end
    step();
    sample_valid = 1'b0;
  endtask

  task automatic pop_exp(output int unsigned lv, output bit cp);
    if (q_lvl.size() == 0) begin
      lv = 99; cp = 1'b0;
    end else begin
      lv = q_lvl.pop_front();
      cp = q_clip.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    left_sample = 32'h7FFF_FFFF; right_sample = 32'h8000_0000;
    ch_mode = 2'd0; gain = 2'd3; sample_valid = 1'b1;
    step(); step();
    checks++; if (leds !== '0)  begin failures++; $display("FAIL reset_leds got %0h want 0", leds); end
    checks++; if (level !== '0) begin failures++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (peak !== '0)  begin failures++; $display("FAIL reset_peak got %0d want 0", peak); end
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL reset_clip got %0b want 0", clip); end
    reset = 1'b0; sample_valid = 1'b0;
    step();
    checks++; if (level !== '0) begin failures++; $display("FAIL reset_after_level got %0d want 0", level); end
  endtask

  task automatic test_level_mapping();
    logic [31:0] tl [8] = '{32'h0000_0000, 32'h001F_FFFF, 32'h0020_0000, 32'h0040_0000,
                           32'h7FFF_FFFF, 32'hFFC0_0000, 32'h2000_0000, 32'h0040_0000};
    logic [1:0]  tg [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3};
    int unsigned lv; bit cp;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      send(tl[i], 32'h0, 2'd0, tg[i], 1'b1);
      step();
      pop_exp(lv, cp);
      checks++; if (32'(level) !== lv) begin failures++; $display("FAIL map_level[%0d] got %0d want %0d", i, level, lv); end
      checks++; if (32'(peak) !== lv)  begin failures++; $display("FAIL map_peak[%0d] got %0d want %0d", i, peak, lv); end
      checks++; if (leds !== exp_leds(lv, lv)) begin failures++; $display("FAIL map_leds[%0d] got %0h want %0h", i, leds, exp_leds(lv, lv)); end
      checks++; if (clip !== cp) begin failures++; $display("FAIL map_clip[%0d] got %0b want %0b", i, clip, cp); end
    end
  endtask

  task automatic test_gain_clip();
    int unsigned lv; bit cp;
    do_reset();
    send(32'h2000_0000, 32'h0, 2'd0, 2'd2, 1'b1);
    step();
    pop_exp(lv, cp);
    checks++; if (32'(level) !== lv) begin failures++; $display("FAIL gain_level got %0d want %0d", level, lv); end
    checks++; if (leds !== exp_leds(lv, lv)) begin failures++; $display("FAIL gain_leds got %0h want %0h", leds, exp_leds(lv, lv)); end
    checks++; if (clip !== cp) begin failures++; $display("FAIL gain_clip got %0b want %0b", clip, cp); end
    for (int k = 1; k <= int'(HC); k++) begin
      step();
      checks++;
      if (clip !== (k < int'(HC))) begin failures++; $display("FAIL clip_hold[%0d] got %0b want %0b", k, clip, (k < int'(HC))); end
    end
    checks++; if (32'(level) !== lv) begin failures++; $display("FAIL gain_level_held got %0d want %0d", level, lv); end
  endtask

  task automatic test_most_negative();
    logic [31:0] tl [2] = '{32'h8000_0000, 32'hE000_0000};
    logic [1:0]  tg [2] = '{2'd0, 2'd2};
    int unsigned lv; bit cp;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      send(tl[i], 32'h0, 2'd0, tg[i], 1'b1);
      step();
      pop_exp(lv, cp);
      checks++; if (clip !== cp) begin failures++; $display("FAIL neg_clip[%0d] got %0b want %0b", i, clip, cp); end
      checks++; if (32'(level) !== lv) begin failures++; $display("FAIL neg_level[%0d] got %0d want %0d", i, level, lv); end
    end
  endtask

  task automatic test_peak_decay();
    int unsigned lv; bit cp;
    int unsigned pk;
    int d;
    do_reset();
    send(32'h4000_0000, 32'h0, 2'd0, 2'd0, 1'b1);
    for (int k = 0; k <= 50; k++) begin
      send(32'h0, 32'h0, 2'd0, 2'd0, 1'b1);
      pop_exp(lv, cp);
      d  = (k < int'(HC)) ? int'(NL) : int'(NL) - (k - int'(HC)) / int'(DC);
      pk = (d < 0) ? 0 : d;
      checks++; if (32'(level) !== lv) begin failures++; $display("FAIL decay_level[%0d] got %0d want %0d", k, level, lv); end
      checks++; if (32'(peak) !== pk)  begin failures++; $display("FAIL decay_peak[%0d] got %0d want %0d", k, peak, pk); end
      checks++; if (leds !== exp_leds(lv, pk)) begin failures++; $display("FAIL decay_leds[%0d] got %0h want %0h", k, leds, exp_leds(lv, pk)); end
    end
  endtask

  task automatic test_channel_modes();
    logic [1:0] tm [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    int unsigned lv; bit cp;
    do_reset();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) send(32'h0010_0000, 32'hFF00_0000, tm[i], 2'd0, 1'b1);
      else step();
      if (i >= 1) begin
        pop_exp(lv, cp);
        checks++; if (32'(level) !== lv) begin failures++; $display("FAIL mode_level[%0d] got %0d want %0d", i - 1, level, lv); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned lv; bit cp;
    logic [31:0] l, r;
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      if (i < 40) begin
        l = $urandom() >> $urandom_range(0, 14);
        r = $urandom() >> $urandom_range(0, 14);
        if ($urandom_range(0, 1) == 1) l = -l;
        send(l, r, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
      end else begin
        step();
      end
      if (i >= 1) begin
        pop_exp(lv, cp);
        checks++; if (32'(level) !== lv) begin failures++; $display("FAIL b2b_level[%0d] got %0d want %0d", i - 1, level, lv); end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int unsigned lv; bit cp;
    do_reset();
    send(32'h0800_0000, 32'h0, 2'd0, 2'd0, 1'b1);
    step();
    pop_exp(lv, cp);
    checks++; if (32'(peak) !== lv) begin failures++; $display("FAIL rst_pre_peak got %0d want %0d", peak, lv); end
    step(); step();
    send(32'h8000_0000, 32'h0, 2'd0, 2'd0, 1'b0);
    reset = 1'b1;
    step();
    checks++; if (peak !== '0)   begin failures++; $display("FAIL rst_peak got %0d want 0", peak); end
    checks++; if (leds !== '0)   begin failures++; $display("FAIL rst_leds got %0h want 0", leds); end
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL rst_clip got %0b want 0", clip); end
    reset = 1'b0;
    step();
    checks++; if (level !== '0)  begin failures++; $display("FAIL rst_flight_level got %0d want 0", level); end
    checks++; if (peak !== '0)   begin failures++; $display("FAIL rst_flight_peak got %0d want 0", peak); end
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL rst_flight_clip got %0b want 0", clip); end
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0;
    left_sample = '0; right_sample = '0; ch_mode = '0; gain = '0;
    test_reset();
    test_level_mapping();
    test_gain_clip();
    test_most_negative();
    test_peak_decay();
    test_channel_modes();
    test_back_to_back();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
